// File: rtl/result_stream_arbiter_pkg.sv
// Shared channel constants and the round-robin grant helper for result_stream_arbiter.
package result_stream_arbiter_pkg;

  localparam int N_CH = 3;
  localparam int CH_W = 2;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] ch;
  } grant_t;

  // Searches last+1, last+2, last+3 (mod N_CH) and returns the first non-empty channel.
  function automatic grant_t rr_next(input logic [CH_W-1:0] last,
                                     input logic [N_CH-1:0] nonempty);
    grant_t          g;
    logic [CH_W-1:0] c;
    g = '0;
    c = last;
    for (int i = 0; i < N_CH; i++) begin
      c = (c == CH_W'(N_CH - 1)) ? '0 : c + 2'd1;
      if (!g.found && nonempty[c]) begin
        g.found = 1'b1;
        g.ch    = c;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small per-channel sample FIFO: combinational head read, push/pop in the same cycle keeps count.
// Caller guarantees no pop when empty and no push when full unless popping in the same cycle.
module sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/result_stream_arbiter.sv
// Round-robin merge of three free-running sample streams onto one tagged valid/ready result port.
// Min one cycle FIFO write to output; sources never stall, so a full FIFO drops and flags overflow.
module result_stream_arbiter
  import result_stream_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic              data_in_valid_0,
  input  logic              data_in_valid_1,
  input  logic              data_in_valid_2,
  output logic [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]   data_out_channel,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  input  logic              clear_overflow,
  output logic [N_CH-1:0]   overflow
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din  [N_CH];
  logic [DATA_W-1:0] dout [N_CH];
  logic [CNT_W-1:0]  cnt  [N_CH];
  logic [N_CH-1:0]   in_vld, want, push, pop, drop, full, empty;
  logic              out_free, load;
  grant_t            grant;

  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d, last_q, last_d;
  logic              vld_q, vld_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign in_vld = {data_in_valid_2, data_in_valid_1, data_in_valid_0};

  assign out_free = !vld_q || data_out_ready;
  assign grant    = rr_next(last_q, ~empty);
  assign load     = out_free && grant.found;

  always_comb begin
    pop = '0;
    if (load) pop[grant.ch] = 1'b1;
  end

  // A full FIFO still takes a write when it is popped on the same edge.
  assign want = in_vld & ch_mask & {N_CH{enable}};
  assign push = want & (~full | pop);
  assign drop = want & full & ~pop;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sample_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push[i]),
      .pop  (pop[i]),
      .din  (din[i]),
      .dout (dout[i]),
      .count(cnt[i]),
      .full (full[i]),
      .empty(empty[i])
    );

    a_fifo_sane: assert property (@(posedge clk) disable iff (reset)
      (cnt[i] <= CNT_W'(DEPTH)) && !(pop[i] && empty[i]));
  end

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load) begin
      data_d = dout[grant.ch];
      ch_d   = grant.ch;
      vld_d  = 1'b1;
      last_d = grant.ch;
    end else if (out_free) begin
      vld_d = 1'b0;
    end
    // A drop on the same edge as a clear leaves that channel's flag set.
    ovf_d = (ovf_q & {N_CH{~clear_overflow}}) | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      last_q <= CH_W'(N_CH - 1);
      ovf_q  <= '0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_out         = data_q;
  assign data_out_channel = ch_q;
  assign data_out_valid   = vld_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_result_stream_arbiter.sv
// Bench for result_stream_arbiter: constant vector table, directed corner sequences, random vs queue model.
module tb_result_stream_arbiter;
  localparam int DEPTH = 4;

  logic        clk, reset, enable, clear_overflow, data_out_ready;
  logic [2:0]  ch_mask, overflow;
  logic [31:0] data_in_0, data_in_1, data_in_2, data_out;
  logic        data_in_valid_0, data_in_valid_1, data_in_valid_2, data_out_valid;
  logic [1:0]  data_out_channel;

  result_stream_arbiter #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .data_in_valid_0(data_in_valid_0), .data_in_valid_1(data_in_valid_1),
    .data_in_valid_2(data_in_valid_2),
    .data_out(data_out), .data_out_channel(data_out_channel),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .clear_overflow(clear_overflow), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per channel plus the presented sample.
  logic [31:0] mq [3][$];
  logic        m_vld;
  logic [1:0]  m_ch;
  logic [31:0] m_dat;
  logic [2:0]  m_ovf;
  int          m_last;
  logic [33:0] rx [$];

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [31:0] d0, d1, d2;
    logic        en;
    logic [2:0]  msk;
    logic        rdy;
    logic        e_vld;
    logic [1:0]  e_ch;
    logic [31:0] e_dat;
    logic [2:0]  e_ovf;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_vld = 1'b0; m_ch = 2'd0; m_dat = 32'h0; m_ovf = 3'b0; m_last = 2;
  endtask

  task automatic model_edge();
    logic [31:0] d [3];
    logic [2:0]  v;
    int          c;
    bit          got;
    d[0] = data_in_0; d[1] = data_in_1; d[2] = data_in_2;
    v = {data_in_valid_2, data_in_valid_1, data_in_valid_0};
    if (!m_vld || data_out_ready) begin
      got = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (!got && mq[c].size() != 0) begin
          got = 1; m_dat = mq[c].pop_front(); m_ch = 2'(c); m_last = c;
        end
      end
      m_vld = got;
    end
    if (clear_overflow) m_ovf = 3'b0;
    for (int i = 0; i < 3; i++)
      if (v[i] && enable && ch_mask[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i]);
        else m_ovf[i] = 1'b1;
      end
  endtask

  task automatic drive_tick(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic e, input logic [2:0] m,
                            input logic r, input logic cl);
    data_in_valid_0 = v[0]; data_in_valid_1 = v[1]; data_in_valid_2 = v[2];
    data_in_0 = a; data_in_1 = b; data_in_2 = c;
    enable = e; ch_mask = m; data_out_ready = r; clear_overflow = cl;
    if (data_out_valid && data_out_ready) rx.push_back({data_out_channel, data_out});
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic chk_model(input string nm);
    chk(nm, 64'({data_out_valid, data_out_channel, data_out, overflow}),
            64'({m_vld, m_ch, m_dat, m_ovf}));
  endtask

  task automatic cyc(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic e, input logic [2:0] m,
                     input logic r, input logic cl, input string nm);
    drive_tick(v, a, b, c, e, m, r, cl);
    chk_model(nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in_valid_0 = 0; data_in_valid_1 = 0; data_in_valid_2 = 0;
    data_in_0 = 0; data_in_1 = 0; data_in_2 = 0;
    enable = 1'b1; ch_mask = 3'b111; data_out_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           rst   vld     d0      d1      d2    en  msk     rdy  e_vld e_ch   e_dat   e_ovf
    tbl[0]  = '{1'b1, 3'b010, 32'h0,  32'hA5, 32'h0,  1, 3'b111, 1,  1'b0, 2'd0, 32'h00, 3'b0};
    tbl[1]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b1, 2'd1, 32'hA5, 3'b0};
    tbl[2]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b0, 2'd1, 32'hA5, 3'b0};
    tbl[3]  = '{1'b1, 3'b111, 32'h10, 32'h20, 32'h30, 1, 3'b111, 1,  1'b0, 2'd0, 32'h00, 3'b0};
    tbl[4]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b1, 2'd0, 32'h10, 3'b0};
    tbl[5]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b1, 2'd1, 32'h20, 3'b0};
    tbl[6]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b1, 2'd2, 32'h30, 3'b0};
    tbl[7]  = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b0, 2'd2, 32'h30, 3'b0};
    tbl[8]  = '{1'b0, 3'b001, 32'h55, 32'h0,  32'h0,  0, 3'b111, 1,  1'b0, 2'd2, 32'h30, 3'b0};
    tbl[9]  = '{1'b0, 3'b001, 32'h66, 32'h0,  32'h0,  1, 3'b110, 1,  1'b0, 2'd2, 32'h30, 3'b0};
    tbl[10] = '{1'b0, 3'b000, 32'h0,  32'h0,  32'h0,  1, 3'b111, 1,  1'b0, 2'd2, 32'h30, 3'b0};

    do_reset();
    chk("reset_state", 64'({data_out_valid, data_out_channel, data_out, overflow}), 64'(0));

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      drive_tick(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].en, tbl[i].msk,
                 tbl[i].rdy, 1'b0);
      chk($sformatf("tbl[%0d]", i),
          64'({data_out_valid, data_out_channel, data_out, overflow}),
          64'({tbl[i].e_vld, tbl[i].e_ch, tbl[i].e_dat, tbl[i].e_ovf}));
    end

    // ch2 burst with the consumer stalled: 5 kept, 6th dropped.
    do_reset(); rx.delete();
    for (int k = 0; k < 6; k++) cyc(3'b100, 0, 0, 32'h200 + k, 1, 3'b111, 0, 0, "ovf_fill");
    chk("ovf_ch2", 64'(overflow), 64'(3'b100));
    chk("ovf_hold", 64'({data_out_valid, data_out}), 64'({1'b1, 32'h200}));
    repeat (6) cyc(0, 0, 0, 0, 1, 3'b111, 1, 0, "ovf_drain");
    chk("ovf_rx_count", 64'(rx.size()), 64'(5));
    for (int k = 0; k < 5; k++)
      chk("ovf_rx_order", (rx.size() > k) ? 64'(rx[k]) : 64'h1, 64'({2'd2, 32'h200 + k}));

    // Clear coinciding with a fresh drop on ch0 keeps the flag; a bare clear clears it.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(3'b001, 32'h100 + k, 0, 0, 1, 3'b111, 0, 0, "clr_fill");
    cyc(3'b001, 32'h1FF, 0, 0, 1, 3'b111, 0, 1, "clr_drop");
    chk("clr_set_wins", 64'(overflow), 64'(3'b001));
    cyc(0, 0, 0, 0, 1, 3'b111, 0, 1, "clr_only");
    chk("clr_clears", 64'(overflow), 64'(3'b000));

    // Full ch0 FIFO popped and pushed on the same edge: no drop.
    do_reset(); rx.delete();
    for (int k = 0; k < 5; k++) cyc(3'b001, 32'h300 + k, 0, 0, 1, 3'b111, 0, 0, "full_fill");
    cyc(3'b001, 32'h305, 0, 0, 1, 3'b111, 1, 0, "full_pushpop");
    chk("full_no_ovf", 64'(overflow), 64'(3'b000));
    repeat (6) cyc(0, 0, 0, 0, 1, 3'b111, 1, 0, "full_drain");
    chk("full_rx_count", 64'(rx.size()), 64'(6));
    for (int k = 0; k < 6; k++)
      chk("full_rx_order", (rx.size() > k) ? 64'(rx[k]) : 64'h1, 64'({2'd0, 32'h300 + k}));

    // Asynchronous reset while three samples are in flight.
    do_reset();
    cyc(3'b111, 32'h1, 32'h2, 32'h3, 1, 3'b111, 0, 0, "rst_load");
    cyc(0, 0, 0, 0, 1, 3'b111, 0, 0, "rst_present");
    chk("rst_pre_vld", 64'(data_out_valid), 64'(1));
    reset = 1'b1;
    #2;
    chk("rst_async", 64'({data_out_valid, data_out_channel, data_out, overflow}), 64'(0));
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) cyc(0, 0, 0, 0, 1, 3'b111, 1, 0, "rst_after_idle");
    chk("rst_after_vld", 64'(data_out_valid), 64'(0));

    // Random traffic against the queue model.
    do_reset();
    for (int n = 0; n < 1500; n++)
      cyc(3'($urandom) & 3'($urandom), $urandom, $urandom, $urandom,
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
